// File: rtl/i2c_slave_device.sv
// I2C slave endpoint with a fixed 7-bit address.
// SCL/SDA are oversampled on CLK through 2-FF synchronizers plus a history FF.
// The slave ACKs its address, returns written bytes on rx_data/rx_valid,
// and shifts tx_data out MSB first on reads. SDA is open-drain: drive 0 or Z.
module i2c_slave_device #(
    parameter logic [6:0] ADDR = 7'b1100111
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_RX_DATA,
        S_ACK_DATA,
        S_TX_DATA,
        S_WAIT_MACK,
        S_IGNORE
    } state_t;

    // synchronizer and history registers (reset to the idle bus level)
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // protocol state
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        addr_match_q, addr_match_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        sda_low_q, sda_low_d;
    logic        sda_out_q;

    // bus events decoded from the synchronized levels
    logic scl_rise, scl_fall, scl_high, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign scl_high  = scl_s2_q & scl_h_q;
    assign start_det = scl_high & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_high & ~sda_h_q & sda_s2_q;
    assign rx_byte   = {sh_q[6:0], sda_s2_q};

    // open-drain pad: only ever pull low or release
    assign SDA = sda_out_q ? 1'b0 : 1'bz;

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign rw         = rw_q;
    assign busy       = busy_q;

    // two-stage synchronizers followed by a one-stage history for edge detection
    always_ff @(posedge CLK) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= SCL;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= SDA;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    // state and datapath register update
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            last_q       <= 1'b0;
            sh_q         <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            sda_low_q    <= 1'b0;
            sda_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            sh_q         <= sh_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            sda_low_q    <= sda_low_d;
            sda_out_q    <= sda_low_q;
        end
    end

    // next-state logic: START/STOP override everything, then per-state bit handling
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        sh_d         = sh_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        sda_low_d    = sda_low_q;

        if (start_det) begin
            // covers both a fresh START and a repeated START
            state_d      = S_ADDR;
            cnt_d        = 3'd0;
            last_d       = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            sda_low_d    = 1'b0;
        end else if (stop_det) begin
            // any partial byte is simply abandoned
            state_d      = S_IDLE;
            cnt_d        = 3'd0;
            last_d       = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            sda_low_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    sda_low_d = 1'b0;
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        sh_d = rx_byte;
                        if (cnt_q == 3'd7) begin
                            // rx_byte[0] is the R/W bit, sh_q[6:0] the address
                            rw_d    = sda_s2_q;
                            cnt_d   = 3'd0;
                            last_d  = 1'b0;
                            state_d = (sh_q[6:0] == ADDR) ? S_ACK_ADDR : S_IGNORE;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end

                S_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            // fall after the 8th bit: start the ACK
                            sda_low_d    = 1'b1;
                            addr_match_d = 1'b1;
                        end else if (rw_q) begin
                            // fall after the ACK clock: present the first read bit
                            sh_d      = tx_data;
                            sda_low_d = ~tx_data[7];
                            cnt_d     = 3'd0;
                            last_d    = 1'b0;
                            state_d   = S_TX_DATA;
                        end else begin
                            sda_low_d = 1'b0;
                            cnt_d     = 3'd0;
                            last_d    = 1'b0;
                            state_d   = S_RX_DATA;
                        end
                    end
                end

                S_RX_DATA: begin
                    if (scl_rise && !last_q) begin
                        sh_d = rx_byte;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                            last_d     = 1'b1;
                            cnt_d      = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (scl_fall && last_q) begin
                        sda_low_d = 1'b1;
                        last_d    = 1'b0;
                        state_d   = S_ACK_DATA;
                    end
                end

                S_ACK_DATA: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        cnt_d     = 3'd0;
                        last_d    = 1'b0;
                        state_d   = S_RX_DATA;
                    end
                end

                S_TX_DATA: begin
                    if (scl_rise && !last_q) begin
                        if (cnt_q == 3'd7) begin
                            last_d = 1'b1;
                            cnt_d  = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (scl_fall) begin
                        if (last_q) begin
                            // bit 0 has been clocked: hand SDA to the master for its ACK
                            sda_low_d = 1'b0;
                            last_d    = 1'b0;
                            state_d   = S_WAIT_MACK;
                        end else begin
                            sh_d      = {sh_q[6:0], 1'b0};
                            sda_low_d = ~sh_q[6];
                        end
                    end
                end

                S_WAIT_MACK: begin
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            last_d = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && last_q) begin
                        sh_d      = tx_data;
                        sda_low_d = ~tx_data[7];
                        cnt_d     = 3'd0;
                        last_d    = 1'b0;
                        state_d   = S_TX_DATA;
                    end
                end

                S_IGNORE: begin
                    sda_low_d = 1'b0;
                end

                default: begin
                    state_d   = S_IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_device.sv
// Directed bench for i2c_slave_device: a bit-banged master drives SCL/SDA
// with a 10-CLK low phase and 8-CLK high phase per bit.
module tb_i2c_slave_device;

    logic       CLK = 1'b0;
    logic       reset;
    logic       SCL;
    logic       m_sda_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       rw;
    logic       busy;
    wire        SDA;

    int checks = 0;
    int fails  = 0;

    // activity counters kept by free-running monitors
    int   rxv_hi     = 0;
    int   rxv_pulses = 0;
    int   slave_low  = 0;
    int   busy_low   = 0;
    logic rxv_prev   = 1'b0;
    logic busy_mon   = 1'b0;
    logic last_sda;

    assign SDA = m_sda_low ? 1'b0 : 1'bz;
    pullup (SDA);

    i2c_slave_device dut (
        .CLK       (CLK),
        .reset     (reset),
        .SCL       (SCL),
        .SDA       (SDA),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_match(addr_match),
        .rw        (rw),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (rx_valid) rxv_hi <= rxv_hi + 1;
        if (rx_valid && !rxv_prev) rxv_pulses <= rxv_pulses + 1;
        rxv_prev <= rx_valid;
        if (busy_mon && !busy) busy_low <= busy_low + 1;
    end

    always @(posedge CLK) begin
        if (!m_sda_low && SDA === 1'b0) slave_low <= slave_low + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // each bit task is entered right after SCL has been pulled low
    task automatic send_bit(input logic b);
        wait_n(6);
        m_sda_low = ~b;
        wait_n(4);
        SCL = 1'b1;
        wait_n(4);
        last_sda = SDA;
        wait_n(4);
        SCL = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_n(6);
        m_sda_low = 1'b0;
        wait_n(4);
        SCL = 1'b1;
        wait_n(4);
        b = SDA;
        wait_n(4);
        SCL = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic [7:0] next_tx, input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        tx_data = next_tx;
        send_bit(nack);
    endtask

    task automatic start_cond();
        wait_n(8);
        m_sda_low = 1'b1;
        wait_n(8);
        SCL = 1'b0;
    endtask

    task automatic rstart_cond();
        wait_n(6);
        m_sda_low = 1'b0;
        wait_n(4);
        SCL = 1'b1;
        wait_n(8);
        m_sda_low = 1'b1;
        wait_n(8);
        SCL = 1'b0;
    endtask

    task automatic stop_cond();
        wait_n(6);
        m_sda_low = 1'b1;
        wait_n(4);
        SCL = 1'b1;
        wait_n(8);
        m_sda_low = 1'b0;
        wait_n(10);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         base_rxv, base_pul, base_low;

        reset     = 1'b1;
        SCL       = 1'b1;
        m_sda_low = 1'b0;
        tx_data   = 8'h00;
        wait_n(4);
        reset = 1'b0;
        wait_n(4);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("rst_addr_match", {7'd0, addr_match}, 8'h00);
        chk("rst_rw", {7'd0, rw}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_sda", {7'd0, SDA}, 8'h01);

        // write 0x67+W, 0xAA, STOP
        base_rxv = rxv_hi;
        base_pul = rxv_pulses;
        start_cond();
        write_byte(8'hCE, ack);
        chk("w_addr_ack", {7'd0, ack}, 8'h00);
        chk("w_addr_match", {7'd0, addr_match}, 8'h01);
        write_byte(8'hAA, ack);
        chk("w_data_ack", {7'd0, ack}, 8'h00);
        chk("w_rx_data", rx_data, 8'hAA);
        chk("w_rxv_cycles", 8'(rxv_hi - base_rxv), 8'd1);
        chk("w_rxv_pulses", 8'(rxv_pulses - base_pul), 8'd1);
        chk("w_busy_before_stop", {7'd0, busy}, 8'h01);
        stop_cond();
        chk("w_busy_after_stop", {7'd0, busy}, 8'h00);
        chk("w_match_after_stop", {7'd0, addr_match}, 8'h00);

        // foreign address 0x12+W, data 0xFF
        base_rxv = rxv_hi;
        base_low = slave_low;
        start_cond();
        write_byte(8'h24, ack);
        chk("na_addr_nack", {7'd0, ack}, 8'h01);
        write_byte(8'hFF, ack);
        chk("na_data_nack", {7'd0, ack}, 8'h01);
        chk("na_sda_never_low", 8'(slave_low - base_low), 8'd0);
        chk("na_no_rx_valid", 8'(rxv_hi - base_rxv), 8'd0);
        chk("na_addr_match", {7'd0, addr_match}, 8'h00);
        chk("na_busy", {7'd0, busy}, 8'h01);
        stop_cond();
        chk("na_busy_after_stop", {7'd0, busy}, 8'h00);

        // read 0x67+R, 0x3C, master NACK
        tx_data = 8'h3C;
        start_cond();
        write_byte(8'hCF, ack);
        chk("r1_addr_ack", {7'd0, ack}, 8'h00);
        read_byte(8'h3C, 1'b1, d);
        chk("r1_data", d, 8'h3C);
        chk("r1_sda_released_9th", {7'd0, last_sda}, 8'h01);
        chk("r1_rw", {7'd0, rw}, 8'h01);
        stop_cond();
        chk("r1_busy_idle", {7'd0, busy}, 8'h00);
        chk("r1_rw_after_stop", {7'd0, rw}, 8'h01);

        // read two bytes: 0x81 (ACK) then 0x7E (NACK)
        tx_data = 8'h81;
        start_cond();
        write_byte(8'hCF, ack);
        chk("r2_addr_ack", {7'd0, ack}, 8'h00);
        read_byte(8'h7E, 1'b0, d);
        chk("r2_byte0", d, 8'h81);
        read_byte(8'h7E, 1'b1, d);
        chk("r2_byte1", d, 8'h7E);
        stop_cond();

        // partial write then repeated START to a read
        base_rxv = rxv_hi;
        tx_data  = 8'h5A;
        start_cond();
        wait_n(2);
        busy_mon = 1'b1;
        write_byte(8'hCE, ack);
        chk("rs_w_ack", {7'd0, ack}, 8'h00);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rstart_cond();
        chk("rs_match_cleared", {7'd0, addr_match}, 8'h00);
        write_byte(8'hCF, ack);
        chk("rs_r_ack", {7'd0, ack}, 8'h00);
        chk("rs_rw", {7'd0, rw}, 8'h01);
        chk("rs_addr_match", {7'd0, addr_match}, 8'h01);
        chk("rs_no_rx_valid", 8'(rxv_hi - base_rxv), 8'd0);
        chk("rs_rx_data_kept", rx_data, 8'hAA);
        read_byte(8'h5A, 1'b1, d);
        chk("rs_data", d, 8'h5A);
        busy_mon = 1'b0;
        wait_n(1);
        chk("rs_busy_never_low", 8'(busy_low), 8'd0);
        stop_cond();

        // reset in the middle of the address ACK
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : ((8'hCE >> i) & 8'h01) != 8'h00);
        wait_n(5);
        m_sda_low = 1'b0;
        wait_n(1);
        chk("mr_sda_ack_low", {7'd0, SDA}, 8'h00);
        reset = 1'b1;
        wait_n(1);
        chk("mr_sda_released", {7'd0, SDA}, 8'h01);
        chk("mr_rx_data", rx_data, 8'h00);
        chk("mr_rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("mr_addr_match", {7'd0, addr_match}, 8'h00);
        chk("mr_rw", {7'd0, rw}, 8'h00);
        chk("mr_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        wait_n(4);
        SCL = 1'b1;
        wait_n(8);
        start_cond();
        write_byte(8'hCE, ack);
        chk("mr_reack", {7'd0, ack}, 8'h00);
        chk("mr_match_again", {7'd0, addr_match}, 8'h01);
        stop_cond();
        chk("mr_busy_end", {7'd0, busy}, 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_device.md
# i2c_slave_device

I2C slave endpoint that sits directly downstream of the bus master. It receives the master's START, 7-bit address, R/W bit and data bytes. It ACKs its own address, delivers written bytes to the local side, and shifts out local data on reads. SCL and SDA are oversampled on the slave's own system clock and synchronized internally.

## Interface
- ADDR, 7'b1100111, 7-bit slave address matched against the address phase (MSB first)
- CLK  input  1  system clock; frequency ≥ 8× SCL frequency
- reset  input  1  synchronous, active-high
- SCL  input  1  bus clock from master (idle high)
- SDA  inout  1  open-drain: slave drives 0 or releases to Z, never drives 1; bench provides pull-up
- tx_data  input  8  byte to return on reads; sampled at load points (see Operation)
- rx_data  output  8  last byte written by master
- rx_valid  output  1  one-CLK pulse when rx_data updates
- addr_match  output  1  high from address ACK until STOP/repeated START
- rw  output  1  R/W bit of current transfer (1 = read)
- busy  output  1  high from START detect until STOP detect

## Operation
- SCL and SDA each pass through a 2-FF synchronizer, then a 1-FF history register for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in every state; they take priority over bit sampling in the same cycle.
- Data bits are sampled on the synchronized SCL rising edge. The slave changes its SDA drive only on the synchronized SCL falling edge.
- Bit counter is 3 bits plus a last-bit flag. Bits are shifted MSB first.
- States and transitions:
  - IDLE: release SDA. START → ADDR, with count reset and busy set.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th rising edge, latch rw.
    - If the address equals ADDR: → ACK_ADDR. At the next SCL fall, drive SDA low and set addr_match.
    - Otherwise → IGNORE.
  - ACK_ADDR: hold SDA low through the 9th SCL high phase. At the 9th fall:
    - rw = 0: release SDA → RX_DATA.
    - rw = 1: load tx_data into the shift register, drive bit 7 → TX_DATA.
  - RX_DATA: shift 8 bits. On the 8th rising edge, update rx_data and pulse rx_valid. At the next fall, drive SDA low → ACK_DATA.
  - ACK_DATA: at the 9th fall, release SDA → RX_DATA (unbounded byte count).
  - TX_DATA: on each fall, drive the next bit (0 → drive low, 1 → release). After bit 0's high phase, release SDA at the fall → WAIT_MACK.
  - WAIT_MACK: sample SDA on the 9th rising edge.
    - 0 (ACK): at the next fall, load tx_data, drive bit 7 → TX_DATA.
    - 1 (NACK): → IGNORE.
  - IGNORE: SDA released. Wait for START → ADDR, or STOP → IDLE.
- STOP in any state → IDLE. SDA is released, busy and addr_match are cleared, and a partial byte is discarded with no rx_valid.
- Repeated START in any state → ADDR. addr_match is cleared and busy stays high.
- reset: all registers return to reset values in the same cycle. SDA is released on the CLK edge where reset is sampled.

## Timing
- Reset values: rx_data 8'h00, rx_valid 0, addr_match 0, rw 0, busy 0, SDA Z, state IDLE, synchronizer registers 1.
- Pin-to-detect latency: an SCL/SDA pin change is acted on 3 CLK after it occurs.
- SDA drive changes 1 CLK after the detected SCL fall, so 4 CLK after the pin edge. This needs an SCL low phase of ≥ 5 CLK for data to be set up before the SCL rise.
- rx_valid asserts 1 CLK after the detected 8th data-bit rising edge and lasts exactly 1 CLK.
- tx_data must be stable from 1 CLK before the load point until 1 CLK after it.
- START/STOP require SDA stable ≥ 3 CLK around SCL high transitions. Glitches shorter than 2 CLK are not guaranteed to be rejected.

## Test plan
- Write 0x67+W, data 0xAA, STOP → SDA low on both 9th clocks; rx_data=0xAA; rx_valid exactly one pulse; busy falls after STOP; addr_match 1 during transfer, then 0.
- Address 0x12+W, data 0xFF → SDA never driven low; no rx_valid; addr_match stays 0; busy 1 until STOP.
- Read 0x67+R, tx_data=0x3C, master NACK, STOP → SDA bits 0,0,1,1,1,1,0,0; released at 9th clock; state IDLE; rw=1.
- Read 0x67+R, tx_data 0x81 then 0x7E, master ACK then NACK → two bytes returned correctly; tx_data reloaded at the 9th fall after the ACK.
- Write 0x67+W, 4 bits of data, repeated START, 0x67+R → partial byte dropped with no rx_valid; new address ACKed; rw=1; busy never drops.
- reset asserted mid-ACK (SDA held low) → SDA released next CLK; all outputs at reset values; next START+0x67 is ACKed normally.
